lsu_ctrl: RTL and testbench

Load/store sequencer between the EX stage and the data-memory bus. It takes the decoded memory operation (load/store flag, func3, effective address, store data) and runs one bus transaction per access. It generates byte enables and store-data lane replication, aligns and extends load data, and detects misaligned and faulting accesses. While a transaction is outstanding it asserts a pipeline stall.

---
 rtl/lsu_ctrl_if.sv | 22 ++
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus interface between the load/store sequencer (master) and memory (slave).
// The master issues one request and holds it until the slave answers with bus_ready.
interface lsu_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_err, bus_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one data-bus transaction per memory instruction, with
// byte-enable generation, store lane replication, load alignment/extension,
// misalignment detection and bus fault reporting. Stalls the pipeline while busy.
// Optional feature macro: LSU_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES
// cycles without bus_ready and reports it as an access fault.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd_addr,
    output logic              lsu_stall,
    lsu_ctrl_if.master        bus,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd_addr,
    output logic              load_misalign,
    output logic              store_misalign,
    output logic              access_fault,
    output logic [31:0]       exc_addr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic        is_load, is_store, legal, aligned;
    logic        start, misalign, timeout_hit, access_done;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lat_addr;
    logic [2:0]  lat_func3;
    logic [4:0]  lat_rd;
    logic [31:0] shifted_rdata;
    logic [31:0] load_ext;

    // Decode the incoming request: legality, alignment, lane enables and store data.
    always_comb begin
        is_load    = req_rd;
        is_store   = req_wr & ~req_rd;
        legal      = 1'b0;
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        if (is_load) begin
            legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                    (req_func3 == 3'b100) || (req_func3 == 3'b101);
        end else if (is_store) begin
            legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
        end
        case (req_func3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned    = ~req_addr[0];
                be_next    = 4'b0011 << req_addr[1:0];
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: begin
                aligned    = (req_addr[1:0] == 2'b00);
            end
        endcase
        start    = (state == IDLE) & req_valid & legal & aligned;
        misalign = (state == IDLE) & req_valid & legal & ~aligned;
    end

`ifdef LSU_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Count ACCESS cycles spent waiting on the bus; restarted for every new access.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 16'd0;
        end else if (start) begin
            wait_cnt <= 16'd0;
        end else if ((state == ACCESS) && !bus.bus_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ACCESS) & ~bus.bus_ready &
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    assign access_done = (state == ACCESS) & (bus.bus_ready | timeout_hit);
    assign lsu_stall   = start | ((state == ACCESS) & ~bus.bus_ready & ~timeout_hit);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: enter ACCESS on a legal aligned request, leave on completion or timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCESS;
            ACCESS:  if (access_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pick the addressed byte/half out of the read word and sign- or zero-extend it.
    always_comb begin
        shifted_rdata = bus.bus_rdata >> {lat_addr[1:0], 3'b000};
        case (lat_func3[1:0])
            2'b00:   load_ext = {{24{~lat_func3[2] & shifted_rdata[7]}}, shifted_rdata[7:0]};
            2'b01:   load_ext = {{16{~lat_func3[2] & shifted_rdata[15]}}, shifted_rdata[15:0]};
            default: load_ext = shifted_rdata;
        endcase
    end

    // Bus request registers, latched request context, writeback and exception pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bus_req    <= 1'b0;
            bus.bus_we     <= 1'b0;
            bus.bus_addr   <= 32'd0;
            bus.bus_be     <= 4'd0;
            bus.bus_wdata  <= 32'd0;
            lat_addr       <= 32'd0;
            lat_func3      <= 3'd0;
            lat_rd         <= 5'd0;
            wb_valid       <= 1'b0;
            wb_data        <= 32'd0;
            wb_rd_addr     <= 5'd0;
            load_misalign  <= 1'b0;
            store_misalign <= 1'b0;
            access_fault   <= 1'b0;
            exc_addr       <= 32'd0;
        end else begin
            wb_valid       <= 1'b0;
            load_misalign  <= 1'b0;
            store_misalign <= 1'b0;
            access_fault   <= 1'b0;
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= is_store;
                bus.bus_addr  <= {req_addr[31:2], 2'b00};
                bus.bus_be    <= be_next;
                bus.bus_wdata <= wdata_next;
                lat_addr      <= req_addr;
                lat_func3     <= req_func3;
                lat_rd        <= req_rd_addr;
            end else if (access_done) begin
                bus.bus_req <= 1'b0;
                if (bus.bus_ready) begin
                    if (bus.bus_err) begin
                        access_fault <= 1'b1;
                        exc_addr     <= lat_addr;
                    end else if (!bus.bus_we) begin
                        wb_valid   <= 1'b1;
                        wb_data    <= load_ext;
                        wb_rd_addr <= lat_rd;
                    end
                end else begin
                    access_fault <= 1'b1;
                    exc_addr     <= lat_addr;
                end
            end
            if (misalign) begin
                load_misalign  <= is_load;
                store_misalign <= is_store;
                exc_addr       <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed-vector bench for lsu_ctrl: a table of load/store requests with
// hand-computed bus fields and results, plus reset, idle-bus and timeout sequences.
module tb_lsu_ctrl;

    localparam logic [2:0] K_WB   = 3'd0;
    localparam logic [2:0] K_ST   = 3'd1;
    localparam logic [2:0] K_FLT  = 3'd2;
    localparam logic [2:0] K_LMIS = 3'd3;
    localparam logic [2:0] K_SMIS = 3'd4;
    localparam logic [2:0] K_IGN  = 3'd5;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd_addr;
        logic [3:0]  wait_cycles;
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  kind;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_rd, req_wr;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd_addr;
    logic        lsu_stall, wb_valid, load_misalign, store_misalign, access_fault;
    logic [31:0] wb_data, exc_addr;
    logic [4:0]  wb_rd_addr;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[17];

    lsu_ctrl_if bus_if();

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .req_func3      (req_func3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd_addr    (req_rd_addr),
        .lsu_stall      (lsu_stall),
        .bus            (bus_if.master),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd_addr     (wb_rd_addr),
        .load_misalign  (load_misalign),
        .store_misalign (store_misalign),
        .access_fault   (access_fault),
        .exc_addr       (exc_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        logic bus_kind;
        bus_kind    = (v.kind == K_WB) || (v.kind == K_ST) || (v.kind == K_FLT);
        req_valid   = 1'b1;
        req_rd      = v.rd;
        req_wr      = v.wr;
        req_func3   = v.func3;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_rd_addr = v.rd_addr;
        #1;
        check_output($sformatf("v%0d_stall_issue", idx), {31'd0, lsu_stall}, {31'd0, bus_kind});
        step();
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        if (bus_kind) begin
            check_output($sformatf("v%0d_bus_req", idx), {31'd0, bus_if.bus_req}, 32'd1);
            check_output($sformatf("v%0d_bus_we", idx), {31'd0, bus_if.bus_we}, {31'd0, v.exp_we});
            check_output($sformatf("v%0d_bus_be", idx), {28'd0, bus_if.bus_be}, {28'd0, v.exp_be});
            check_output($sformatf("v%0d_bus_addr", idx), bus_if.bus_addr, v.exp_addr);
            check_output($sformatf("v%0d_bus_wdata", idx), bus_if.bus_wdata, v.exp_wdata);
            for (int i = 0; i < int'(v.wait_cycles); i++) begin
                check_output($sformatf("v%0d_stall_wait", idx), {31'd0, lsu_stall}, 32'd1);
                step();
            end
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = v.rdata;
            bus_if.bus_err   = v.err;
            #1;
            check_output($sformatf("v%0d_stall_ready", idx), {31'd0, lsu_stall}, 32'd0);
            step();
            bus_if.bus_ready = 1'b0;
            bus_if.bus_err   = 1'b0;
            check_output($sformatf("v%0d_bus_req_drop", idx), {31'd0, bus_if.bus_req}, 32'd0);
        end else begin
            check_output($sformatf("v%0d_no_bus_req", idx), {31'd0, bus_if.bus_req}, 32'd0);
        end
        check_output($sformatf("v%0d_wb_valid", idx), {31'd0, wb_valid}, {31'd0, v.kind == K_WB});
        check_output($sformatf("v%0d_fault", idx), {31'd0, access_fault}, {31'd0, v.kind == K_FLT});
        check_output($sformatf("v%0d_lmis", idx), {31'd0, load_misalign}, {31'd0, v.kind == K_LMIS});
        check_output($sformatf("v%0d_smis", idx), {31'd0, store_misalign}, {31'd0, v.kind == K_SMIS});
        if (v.kind == K_WB) begin
            check_output($sformatf("v%0d_wb_data", idx), wb_data, v.exp_wb);
            check_output($sformatf("v%0d_wb_rd", idx), {27'd0, wb_rd_addr}, {27'd0, v.rd_addr});
        end
        if ((v.kind == K_FLT) || (v.kind == K_LMIS) || (v.kind == K_SMIS)) begin
            check_output($sformatf("v%0d_exc_addr", idx), exc_addr, v.addr);
        end
    endtask

    initial begin
        //          rd    wr    f3      addr          wdata         rd  wait  rdata         err   kind    we    be       bus_addr      bus_wdata     wb
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd5,  4'd3, 32'h80AA_BBCC, 1'b0, K_WB,   1'b0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        5'd7,  4'd0, 32'h9234_5678, 1'b0, K_WB,   1'b0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_9234};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 5'd0, 4'd1, 32'h0,        1'b0, K_ST,   1'b1, 4'b0010, 32'h0000_3000, 32'hA5A5_A5A5, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0,        5'd1,  4'd0, 32'h0,        1'b0, K_LMIS, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_4001, 32'h0,        5'd0,  4'd0, 32'h0,        1'b0, K_SMIS, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, 32'h0000_5008, 32'h1234_5678, 5'd0, 4'd0, 32'h0,        1'b1, K_FLT,  1'b1, 4'b1111, 32'h0000_5008, 32'h1234_5678, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0,        5'd3,  4'd2, 32'hDEAD_BEEF, 1'b0, K_WB,   1'b0, 4'b1111, 32'h0000_6000, 32'h0,        32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0,        5'd9,  4'd1, 32'h8001_1234, 1'b0, K_WB,   1'b0, 4'b1100, 32'h0000_7000, 32'h0,        32'hFFFF_8001};
        vecs[8]  = '{1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'h0,        5'd10, 4'd0, 32'h1234_F0AB, 1'b0, K_WB,   1'b0, 4'b0010, 32'h0000_7000, 32'h0,        32'h0000_00F0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_8000, 32'h0,        5'd2,  4'd0, 32'h0,        1'b0, K_IGN,  1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h0000_8004, 32'h0,        5'd0,  4'd0, 32'h0,        1'b0, K_IGN,  1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_9002, 32'hCAFE_BEEF, 5'd0, 4'd0, 32'h0,        1'b0, K_ST,   1'b1, 4'b1100, 32'h0000_9000, 32'hBEEF_BEEF, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'b000, 32'h0000_A000, 32'h0000_0011, 5'd4, 4'd0, 32'h0000_007F, 1'b0, K_WB,   1'b0, 4'b0001, 32'h0000_A000, 32'h1111_1111, 32'h0000_007F};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_B001, 32'h0,        5'd6,  4'd0, 32'h0,        1'b1, K_FLT,  1'b0, 4'b0010, 32'h0000_B000, 32'h0,        32'h0};
        vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_C002, 32'h0,        5'd8,  4'd0, 32'h00FF_0000, 1'b0, K_WB,   1'b0, 4'b0100, 32'h0000_C000, 32'h0,        32'hFFFF_FFFF};
        vecs[15] = '{1'b0, 1'b1, 3'b010, 32'h0000_D003, 32'h0,        5'd0,  4'd0, 32'h0,        1'b0, K_SMIS, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
        vecs[16] = '{1'b1, 1'b0, 3'b001, 32'h0000_E001, 32'h0,        5'd1,  4'd0, 32'h0,        1'b0, K_LMIS, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};

        rst              = 1'b1;
        req_valid        = 1'b0;
        req_rd           = 1'b0;
        req_wr           = 1'b0;
        req_func3        = 3'd0;
        req_addr         = 32'd0;
        req_wdata        = 32'd0;
        req_rd_addr      = 5'd0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = 32'd0;
        step();
        step();
        check_output("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        check_output("rst_bus_be", {28'd0, bus_if.bus_be}, 32'd0);
        check_output("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check_output("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check_output("rst_wb_data", wb_data, 32'd0);
        check_output("rst_exc_addr", exc_addr, 32'd0);
        rst = 1'b0;
        step();

        // Vectors run back to back: each new request is issued in the IDLE cycle after completion.
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i], i);
        end
        step();
        check_output("pulse_clear_lmis", {31'd0, load_misalign}, 32'd0);
        check_output("wb_data_hold", wb_data, 32'hFFFF_FFFF);

        // Bus responses while IDLE must be ignored.
        bus_if.bus_ready = 1'b1;
        bus_if.bus_err   = 1'b1;
        step();
        bus_if.bus_ready = 1'b0;
        bus_if.bus_err   = 1'b0;
        check_output("idle_ready_fault", {31'd0, access_fault}, 32'd0);
        check_output("idle_ready_wb", {31'd0, wb_valid}, 32'd0);
        step();

        // Reset in the middle of an access, even with bus_ready present, leaves no trace.
        req_valid   = 1'b1;
        req_rd      = 1'b1;
        req_func3   = 3'b010;
        req_addr    = 32'h0000_F000;
        req_rd_addr = 5'd12;
        step();
        req_valid = 1'b0;
        req_rd    = 1'b0;
        check_output("mid_rst_pre_req", {31'd0, bus_if.bus_req}, 32'd1);
        rst              = 1'b1;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        step();
        rst              = 1'b0;
        bus_if.bus_ready = 1'b0;
        check_output("mid_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        check_output("mid_rst_wb", {31'd0, wb_valid}, 32'd0);
        check_output("mid_rst_fault", {31'd0, access_fault}, 32'd0);
        check_output("mid_rst_stall", {31'd0, lsu_stall}, 32'd0);
        check_output("mid_rst_wb_data", wb_data, 32'd0);
        step();

`ifdef LSU_TIMEOUT_EN
        // Unanswered access: bus_req holds for 4 ACCESS cycles, then a single access_fault.
        req_valid = 1'b1;
        req_rd    = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h0000_F100;
        step();
        req_valid = 1'b0;
        req_rd    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("to_bus_req", {31'd0, bus_if.bus_req}, 32'd1);
            check_output("to_stall", {31'd0, lsu_stall}, 32'd1);
            step();
        end
        check_output("to_last_req", {31'd0, bus_if.bus_req}, 32'd1);
        check_output("to_last_stall", {31'd0, lsu_stall}, 32'd0);
        step();
        check_output("to_req_drop", {31'd0, bus_if.bus_req}, 32'd0);
        check_output("to_fault", {31'd0, access_fault}, 32'd1);
        check_output("to_exc_addr", exc_addr, 32'h0000_F100);
        step();
        check_output("to_fault_once", {31'd0, access_fault}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
